// File: rtl/sb_pkg.sv
// Shared sideband definitions: framer state encoding, word geometry and the
// header-word builder that inserts the data and control parity bits.
package sb_pkg;

    localparam int SB_WORD_W = 64;
    localparam int SB_DP_BIT = 63;
    localparam int SB_CP_BIT = 62;
    localparam int SB_CNT_W  = 8;

    typedef enum logic [2:0] {
        SB_FRM_IDLE      = 3'd0,
        SB_FRM_WAIT_DATA = 3'd1,
        SB_FRM_SEND_HDR  = 3'd2,
        SB_FRM_SEND_DATA = 3'd3,
        SB_FRM_GAP       = 3'd4
    } sb_frm_state_e;

    // CP covers DP as well as the 62 header payload bits.
    function automatic logic [SB_WORD_W-1:0] sb_hdr_word(input logic [SB_WORD_W-1:0] hdr,
                                                         input logic dp);
        logic [SB_WORD_W-1:0] word;
        word            = hdr;
        word[SB_DP_BIT] = dp;
        word[SB_CP_BIT] = ^{dp, hdr[SB_CP_BIT-1:0]};
        return word;
    endfunction

endpackage

// File: rtl/sb_packet_framer.sv
// Sideband TX packet framer: joins header and optional payload, inserts DP/CP,
// hands 64b words to the serializer and enforces the inter-packet idle gap.
module sb_packet_framer
    import sb_pkg::*;
#(
    parameter int GAP_CYCLES   = 4,
    parameter int DATA_TIMEOUT = 15
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic [SB_WORD_W-1:0] i_hdr,
    input  logic                 i_hdr_valid,
    input  logic                 i_has_data,
    input  logic [SB_WORD_W-1:0] i_data,
    input  logic                 i_d_valid,
    output logic                 o_busy,
    output logic [SB_WORD_W-1:0] o_frame,
    output logic                 o_frame_valid,
    input  logic                 i_ser_ready,
    output logic                 o_pkt_done,
    output logic                 o_err_timeout,
    output logic                 o_err_overrun
);

    localparam logic [SB_CNT_W-1:0] GAP_LAST = SB_CNT_W'(GAP_CYCLES - 1);
    localparam logic [SB_CNT_W-1:0] TMO_LAST = SB_CNT_W'(DATA_TIMEOUT - 1);
    localparam logic [SB_CNT_W-1:0] CNT_MAX  = {SB_CNT_W{1'b1}};

    sb_frm_state_e          state_q, state_d;
    logic [SB_WORD_W-1:0]   hdr_q, hdr_d;
    logic [SB_WORD_W-1:0]   data_q, data_d;
    logic                   dp_q, dp_d;
    logic                   has_data_q, has_data_d;
    logic [SB_CNT_W-1:0]    cnt_q, cnt_d;
    logic [SB_WORD_W-1:0]   frame_q, frame_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   busy_q, busy_d;
    logic                   err_to_q, err_to_d;
    logic                   err_ov_q, err_ov_d;
    logic                   accept;
    logic [SB_CNT_W-1:0]    cnt_inc;

    assign accept  = frame_valid_q & i_ser_ready;
    assign cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q       <= SB_FRM_IDLE;
            hdr_q         <= '0;
            data_q        <= '0;
            dp_q          <= 1'b0;
            has_data_q    <= 1'b0;
            cnt_q         <= '0;
            frame_q       <= '0;
            frame_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            err_to_q      <= 1'b0;
            err_ov_q      <= 1'b0;
        end else begin
            state_q       <= state_d;
            hdr_q         <= hdr_d;
            data_q        <= data_d;
            dp_q          <= dp_d;
            has_data_q    <= has_data_d;
            cnt_q         <= cnt_d;
            frame_q       <= frame_d;
            frame_valid_q <= frame_valid_d;
            busy_q        <= busy_d;
            err_to_q      <= err_to_d;
            err_ov_q      <= err_ov_d;
        end
    end

    // A header offered while busy is dropped; it never disturbs the packet in flight.
    always_comb begin
        state_d    = state_q;
        hdr_d      = hdr_q;
        data_d     = data_q;
        dp_d       = dp_q;
        has_data_d = has_data_q;
        cnt_d      = cnt_q;
        err_to_d   = 1'b0;
        err_ov_d   = i_hdr_valid & (state_q != SB_FRM_IDLE);

        unique case (state_q)
            SB_FRM_IDLE: begin
                if (i_hdr_valid) begin
                    hdr_d      = i_hdr;
                    has_data_d = i_has_data;
                    cnt_d      = '0;
                    dp_d       = 1'b0;
                    if (!i_has_data) begin
                        state_d = SB_FRM_SEND_HDR;
                    end else if (i_d_valid) begin
                        data_d  = i_data;
                        dp_d    = ^i_data;
                        state_d = SB_FRM_SEND_HDR;
                    end else begin
                        state_d = SB_FRM_WAIT_DATA;
                    end
                end
            end
            SB_FRM_WAIT_DATA: begin
                // Late data on the timeout cycle still rescues the packet.
                if (i_d_valid) begin
                    data_d  = i_data;
                    dp_d    = ^i_data;
                    state_d = SB_FRM_SEND_HDR;
                end else if (cnt_q >= TMO_LAST) begin
                    err_to_d = 1'b1;
                    cnt_d    = '0;
                    state_d  = SB_FRM_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            SB_FRM_SEND_HDR: begin
                if (i_ser_ready) begin
                    cnt_d   = '0;
                    state_d = has_data_q ? SB_FRM_SEND_DATA : SB_FRM_GAP;
                end
            end
            SB_FRM_SEND_DATA: begin
                if (i_ser_ready) begin
                    cnt_d   = '0;
                    state_d = SB_FRM_GAP;
                end
            end
            SB_FRM_GAP: begin
                if (cnt_q >= GAP_LAST) begin
                    cnt_d   = '0;
                    state_d = SB_FRM_IDLE;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            default: begin
                state_d = SB_FRM_IDLE;
            end
        endcase
    end

    // Output word is built from next-state values so it is valid one cycle after latching.
    always_comb begin
        frame_valid_d = 1'b0;
        frame_d       = '0;
        if (state_d == SB_FRM_SEND_HDR) begin
            frame_valid_d = 1'b1;
            frame_d       = sb_hdr_word(hdr_d, dp_d);
        end else if (state_d == SB_FRM_SEND_DATA) begin
            frame_valid_d = 1'b1;
            frame_d       = data_d;
        end
        busy_d = (state_d != SB_FRM_IDLE);
    end

    assign o_pkt_done    = accept & ((state_q == SB_FRM_SEND_DATA) |
                                     ((state_q == SB_FRM_SEND_HDR) & ~has_data_q));
    assign o_frame       = frame_q;
    assign o_frame_valid = frame_valid_q;
    assign o_busy        = busy_q;
    assign o_err_timeout = err_to_q;
    assign o_err_overrun = err_ov_q;

endmodule

// File: tb/tb_sb_packet_framer.sv
// Self-checking bench for sb_packet_framer: expected words are queued when a
// packet is driven and matched against the words the serializer accepts.
module tb_sb_packet_framer;
    import sb_pkg::*;

    localparam int GAP = 4;
    localparam int TMO = 15;

    logic        i_clk = 1'b0;
    logic        i_rst_n = 1'b0;
    logic [63:0] i_hdr = '0;
    logic        i_hdr_valid = 1'b0;
    logic        i_has_data = 1'b0;
    logic [63:0] i_data = '0;
    logic        i_d_valid = 1'b0;
    logic        i_ser_ready = 1'b0;
    logic        o_busy;
    logic [63:0] o_frame;
    logic        o_frame_valid;
    logic        o_pkt_done;
    logic        o_err_timeout;
    logic        o_err_overrun;

    int errors = 0;
    int checks = 0;

    logic [63:0] expQ[$];
    int          expCyc[$];
    logic [63:0] obsW[$];
    int          obsCyc[$];

    int busyCnt, doneCnt, doneCyc, toCnt, toCyc, ovCnt, ovCyc, firstValid, protoViol;

    always #5 i_clk = ~i_clk;

    sb_packet_framer #(.GAP_CYCLES(GAP), .DATA_TIMEOUT(TMO)) dut (
        .i_clk         (i_clk),
        .i_rst_n       (i_rst_n),
        .i_hdr         (i_hdr),
        .i_hdr_valid   (i_hdr_valid),
        .i_has_data    (i_has_data),
        .i_data        (i_data),
        .i_d_valid     (i_d_valid),
        .o_busy        (o_busy),
        .o_frame       (o_frame),
        .o_frame_valid (o_frame_valid),
        .i_ser_ready   (i_ser_ready),
        .o_pkt_done    (o_pkt_done),
        .o_err_timeout (o_err_timeout),
        .o_err_overrun (o_err_overrun)
    );

    function automatic logic [63:0] modelHdrWord(input logic [63:0] h, input logic dp);
        logic cp;
        cp = dp ^ (^h[61:0]);
        return {dp, cp, h[61:0]};
    endfunction

    // Drives one packet (cycle 0 = header cycle) and records what the DUT does.
    task automatic observe(input logic [63:0] hdr, input logic hasData, input logic [63:0] data,
                           input int dAt, input int rdyLo, input int rdyHi,
                           input int hdr2At, input logic [63:0] hdr2, input int nCycles);
        logic        prevValid, prevReady;
        logic [63:0] prevFrame;
        busyCnt = 0; doneCnt = 0; doneCyc = -1; toCnt = 0; toCyc = -1;
        ovCnt = 0; ovCyc = -1; firstValid = -1; protoViol = 0;
        prevValid = 1'b0; prevReady = 1'b0; prevFrame = '0;
        obsW.delete(); obsCyc.delete();
        i_hdr_valid = 1'b0; i_d_valid = 1'b0; i_ser_ready = 1'b1;
        @(posedge i_clk); #1;
        for (int c = 0; c < nCycles; c++) begin
            i_hdr_valid = (c == 0) || (c == hdr2At);
            i_hdr       = (c == hdr2At) ? hdr2 : hdr;
            i_has_data  = (c == 0) ? hasData : 1'b0;
            i_d_valid   = (c == dAt);
            i_data      = data;
            i_ser_ready = !(c >= rdyLo && c <= rdyHi);
            @(negedge i_clk);
            if (o_busy) busyCnt++;
            if (o_frame_valid && firstValid < 0) firstValid = c;
            if (prevValid && !prevReady && (!o_frame_valid || o_frame !== prevFrame)) protoViol++;
            if (o_frame_valid && i_ser_ready) begin
                obsW.push_back(o_frame);
                obsCyc.push_back(c);
            end
            if (o_pkt_done)    begin doneCnt++; doneCyc = c; end
            if (o_err_timeout) begin toCnt++;   toCyc = c;   end
            if (o_err_overrun) begin ovCnt++;   ovCyc = c;   end
            prevValid = o_frame_valid; prevReady = i_ser_ready; prevFrame = o_frame;
            @(posedge i_clk); #1;
        end
        i_hdr_valid = 1'b0; i_d_valid = 1'b0; i_has_data = 1'b0;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        checks++;
        if ({o_frame_valid, o_busy, o_pkt_done, o_err_timeout, o_err_overrun} !== 5'b0) begin
            errors++;
            $display("[TB] FAIL reset_flags: got %b expected 00000",
                     {o_frame_valid, o_busy, o_pkt_done, o_err_timeout, o_err_overrun});
        end
        checks++;
        if (o_frame !== 64'h0) begin
            errors++;
            $display("[TB] FAIL reset_frame: got %h expected 0", o_frame);
        end
        i_rst_n = 1'b1;
        @(posedge i_clk); #1;
        @(negedge i_clk);
        checks++;
        if (o_busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL reset_idle_busy: got %b expected 0", o_busy);
        end
    endtask

    task automatic test_no_data();
        logic [63:0] expW, gotW;
        int expC, gotC;
        expQ.push_back(64'h4000_0000_0000_0001); expCyc.push_back(1);
        observe(64'h1, 1'b0, 64'h0, -1, -1, -1, -1, 64'h0, 10);
        while (expQ.size() > 0) begin
            expW = expQ.pop_front(); expC = expCyc.pop_front();
            checks++;
            if (obsW.size() == 0) begin
                errors++; $display("[TB] FAIL no_data_word: got none expected %h", expW);
            end else begin
                gotW = obsW.pop_front(); gotC = obsCyc.pop_front();
                if (gotW !== expW || gotC != expC) begin
                    errors++;
                    $display("[TB] FAIL no_data_word: got %h@%0d expected %h@%0d", gotW, gotC, expW, expC);
                end
            end
        end
        checks++;
        if (obsW.size() != 0) begin
            errors++; $display("[TB] FAIL no_data_extra: got %0d extra words expected 0", obsW.size());
        end
        checks++;
        if (firstValid != 1) begin
            errors++; $display("[TB] FAIL no_data_latency: got %0d expected 1", firstValid);
        end
        checks++;
        if (busyCnt != 1 + GAP) begin
            errors++; $display("[TB] FAIL no_data_busy: got %0d expected %0d", busyCnt, 1 + GAP);
        end
        checks++;
        if (doneCnt != 1 || doneCyc != 1) begin
            errors++; $display("[TB] FAIL no_data_done: got %0d@%0d expected 1@1", doneCnt, doneCyc);
        end
        checks++;
        if (toCnt != 0 || ovCnt != 0) begin
            errors++; $display("[TB] FAIL no_data_errs: got to=%0d ov=%0d expected 0 0", toCnt, ovCnt);
        end
    endtask

    task automatic test_data_same();
        logic [63:0] expW, gotW;
        int expC, gotC;
        expQ.push_back(64'hC000_0000_0000_0000); expCyc.push_back(1);
        expQ.push_back(64'h1);                   expCyc.push_back(2);
        observe(64'h0, 1'b1, 64'h1, 0, -1, -1, -1, 64'h0, 12);
        while (expQ.size() > 0) begin
            expW = expQ.pop_front(); expC = expCyc.pop_front();
            checks++;
            if (obsW.size() == 0) begin
                errors++; $display("[TB] FAIL data_same_word: got none expected %h", expW);
            end else begin
                gotW = obsW.pop_front(); gotC = obsCyc.pop_front();
                if (gotW !== expW || gotC != expC) begin
                    errors++;
                    $display("[TB] FAIL data_same_word: got %h@%0d expected %h@%0d", gotW, gotC, expW, expC);
                end
            end
        end
        checks++;
        if (busyCnt != 2 + GAP || doneCyc != 2) begin
            errors++;
            $display("[TB] FAIL data_same_timing: got busy=%0d done@%0d expected busy=%0d done@2",
                     busyCnt, doneCyc, 2 + GAP);
        end
    endtask

    task automatic test_random();
        logic [63:0] h, d, expW, gotW;
        logic        hd;
        int expC, gotC;
        for (int i = 0; i < 4; i++) begin
            h  = {$urandom, $urandom};
            d  = {$urandom, $urandom};
            hd = (i % 2 == 0);
            expQ.push_back(modelHdrWord(h, hd ? ^d : 1'b0)); expCyc.push_back(1);
            if (hd) begin expQ.push_back(d); expCyc.push_back(2); end
            observe(h, hd, d, 0, -1, -1, -1, 64'h0, 10);
            while (expQ.size() > 0) begin
                expW = expQ.pop_front(); expC = expCyc.pop_front();
                checks++;
                if (obsW.size() == 0) begin
                    errors++; $display("[TB] FAIL random_word: got none expected %h", expW);
                end else begin
                    gotW = obsW.pop_front(); gotC = obsCyc.pop_front();
                    if (gotW !== expW || gotC != expC) begin
                        errors++;
                        $display("[TB] FAIL random_word: got %h@%0d expected %h@%0d", gotW, gotC, expW, expC);
                    end
                end
            end
            checks++;
            if (doneCnt != 1 || doneCyc != (hd ? 2 : 1)) begin
                errors++;
                $display("[TB] FAIL random_done: got %0d@%0d expected 1@%0d", doneCnt, doneCyc, hd ? 2 : 1);
            end
        end
    endtask

    task automatic test_data_late();
        logic [63:0] h, d, expW, gotW;
        int dAt, expC, gotC;
        for (int k = 0; k < 2; k++) begin
            dAt = (k == 0) ? 5 : TMO;
            h = {$urandom, $urandom};
            d = {$urandom, $urandom};
            expQ.push_back(modelHdrWord(h, ^d)); expCyc.push_back(dAt + 1);
            expQ.push_back(d);                  expCyc.push_back(dAt + 2);
            observe(h, 1'b1, d, dAt, -1, -1, -1, 64'h0, dAt + 4 + GAP);
            while (expQ.size() > 0) begin
                expW = expQ.pop_front(); expC = expCyc.pop_front();
                checks++;
                if (obsW.size() == 0) begin
                    errors++; $display("[TB] FAIL late_word: got none expected %h", expW);
                end else begin
                    gotW = obsW.pop_front(); gotC = obsCyc.pop_front();
                    if (gotW !== expW || gotC != expC) begin
                        errors++;
                        $display("[TB] FAIL late_word: got %h@%0d expected %h@%0d", gotW, gotC, expW, expC);
                    end
                end
            end
            checks++;
            if (toCnt != 0 || busyCnt != dAt + 2 + GAP) begin
                errors++;
                $display("[TB] FAIL late_status: got to=%0d busy=%0d expected to=0 busy=%0d",
                         toCnt, busyCnt, dAt + 2 + GAP);
            end
        end
    endtask

    task automatic test_timeout();
        observe(64'h1234_5678_9ABC_DEF0, 1'b1, 64'hFF, -1, -1, -1, -1, 64'h0, TMO + 5);
        checks++;
        if (toCnt != 1 || toCyc != TMO + 1) begin
            errors++;
            $display("[TB] FAIL timeout_pulse: got %0d@%0d expected 1@%0d", toCnt, toCyc, TMO + 1);
        end
        checks++;
        if (firstValid != -1 || obsW.size() != 0) begin
            errors++;
            $display("[TB] FAIL timeout_noframe: got first_valid=%0d words=%0d expected -1 0",
                     firstValid, obsW.size());
        end
        checks++;
        if (busyCnt != TMO || doneCnt != 0) begin
            errors++;
            $display("[TB] FAIL timeout_busy: got busy=%0d done=%0d expected %0d 0", busyCnt, doneCnt, TMO);
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] h, d, expW, gotW;
        int expC, gotC;
        h = {$urandom, $urandom};
        d = {$urandom, $urandom};
        expQ.push_back(modelHdrWord(h, ^d)); expCyc.push_back(8);
        expQ.push_back(d);                  expCyc.push_back(9);
        observe(h, 1'b1, d, 0, 1, 7, -1, 64'h0, 11 + GAP);
        while (expQ.size() > 0) begin
            expW = expQ.pop_front(); expC = expCyc.pop_front();
            checks++;
            if (obsW.size() == 0) begin
                errors++; $display("[TB] FAIL backpressure_word: got none expected %h", expW);
            end else begin
                gotW = obsW.pop_front(); gotC = obsCyc.pop_front();
                if (gotW !== expW || gotC != expC) begin
                    errors++;
                    $display("[TB] FAIL backpressure_word: got %h@%0d expected %h@%0d", gotW, gotC, expW, expC);
                end
            end
        end
        checks++;
        if (protoViol != 0 || firstValid != 1) begin
            errors++;
            $display("[TB] FAIL backpressure_hold: got viol=%0d first=%0d expected 0 1", protoViol, firstValid);
        end
        checks++;
        if (doneCyc != 9) begin
            errors++; $display("[TB] FAIL backpressure_done: got %0d expected 9", doneCyc);
        end
    endtask

    task automatic test_overrun();
        logic [63:0] h, expW, gotW;
        int at, expC, gotC;
        for (int k = 0; k < 2; k++) begin
            at = (k == 0) ? 3 : 1 + GAP;
            h  = {$urandom, $urandom};
            expQ.push_back(modelHdrWord(h, 1'b0)); expCyc.push_back(1);
            observe(h, 1'b0, 64'h0, -1, -1, -1, at, 64'hDEAD_BEEF_0000_0001, 10 + GAP);
            while (expQ.size() > 0) begin
                expW = expQ.pop_front(); expC = expCyc.pop_front();
                checks++;
                if (obsW.size() == 0) begin
                    errors++; $display("[TB] FAIL overrun_word: got none expected %h", expW);
                end else begin
                    gotW = obsW.pop_front(); gotC = obsCyc.pop_front();
                    if (gotW !== expW || gotC != expC) begin
                        errors++;
                        $display("[TB] FAIL overrun_word: got %h@%0d expected %h@%0d", gotW, gotC, expW, expC);
                    end
                end
            end
            checks++;
            if (obsW.size() != 0) begin
                errors++; $display("[TB] FAIL overrun_extra: got %0d extra words expected 0", obsW.size());
            end
            checks++;
            if (ovCnt != 1 || ovCyc != at + 1 || busyCnt != 1 + GAP) begin
                errors++;
                $display("[TB] FAIL overrun_pulse: got %0d@%0d busy=%0d expected 1@%0d busy=%0d",
                         ovCnt, ovCyc, busyCnt, at + 1, 1 + GAP);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [63:0] h1, h2, expW, gotW;
        int expC, gotC;
        h1 = {$urandom, $urandom};
        h2 = {$urandom, $urandom};
        expQ.push_back(modelHdrWord(h1, 1'b0)); expCyc.push_back(1);
        expQ.push_back(modelHdrWord(h2, 1'b0)); expCyc.push_back(3 + GAP);
        observe(h1, 1'b0, 64'h0, -1, -1, -1, 2 + GAP, h2, 10 + GAP);
        while (expQ.size() > 0) begin
            expW = expQ.pop_front(); expC = expCyc.pop_front();
            checks++;
            if (obsW.size() == 0) begin
                errors++; $display("[TB] FAIL b2b_word: got none expected %h", expW);
            end else begin
                gotW = obsW.pop_front(); gotC = obsCyc.pop_front();
                if (gotW !== expW || gotC != expC) begin
                    errors++;
                    $display("[TB] FAIL b2b_word: got %h@%0d expected %h@%0d", gotW, gotC, expW, expC);
                end
            end
        end
        checks++;
        if (ovCnt != 0 || doneCnt != 2) begin
            errors++; $display("[TB] FAIL b2b_status: got ov=%0d done=%0d expected 0 2", ovCnt, doneCnt);
        end
    endtask

    task automatic test_reset_mid();
        logic [63:0] h, d, h2, expW, gotW;
        int expC, gotC;
        h  = {$urandom, $urandom};
        d  = {$urandom, $urandom};
        h2 = {$urandom, $urandom};
        @(posedge i_clk); #1;
        i_hdr = h; i_data = d; i_has_data = 1'b1; i_hdr_valid = 1'b1; i_d_valid = 1'b1; i_ser_ready = 1'b1;
        @(posedge i_clk); #1;
        i_hdr_valid = 1'b0; i_d_valid = 1'b0; i_has_data = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_frame_valid !== 1'b1 || o_frame !== modelHdrWord(h, ^d)) begin
            errors++;
            $display("[TB] FAIL rstmid_hdr: got %b/%h expected 1/%h", o_frame_valid, o_frame, modelHdrWord(h, ^d));
        end
        @(posedge i_clk); #1;
        i_ser_ready = 1'b0;
        @(negedge i_clk);
        checks++;
        if (o_frame_valid !== 1'b1 || o_frame !== d) begin
            errors++; $display("[TB] FAIL rstmid_data: got %b/%h expected 1/%h", o_frame_valid, o_frame, d);
        end
        #1 i_rst_n = 1'b0;
        #1;
        checks++;
        if ({o_frame_valid, o_busy, o_pkt_done, o_err_timeout, o_err_overrun} !== 5'b0 || o_frame !== 64'h0) begin
            errors++;
            $display("[TB] FAIL rstmid_async: got flags=%b frame=%h expected 00000 0",
                     {o_frame_valid, o_busy, o_pkt_done, o_err_timeout, o_err_overrun}, o_frame);
        end
        @(posedge i_clk);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        expQ.push_back(modelHdrWord(h2, 1'b0)); expCyc.push_back(1);
        observe(h2, 1'b0, 64'h0, -1, -1, -1, -1, 64'h0, 8 + GAP);
        while (expQ.size() > 0) begin
            expW = expQ.pop_front(); expC = expCyc.pop_front();
            checks++;
            if (obsW.size() == 0) begin
                errors++; $display("[TB] FAIL rstmid_next: got none expected %h", expW);
            end else begin
                gotW = obsW.pop_front(); gotC = obsCyc.pop_front();
                if (gotW !== expW || gotC != expC) begin
                    errors++;
                    $display("[TB] FAIL rstmid_next: got %h@%0d expected %h@%0d", gotW, gotC, expW, expC);
                end
            end
        end
        checks++;
        if (obsW.size() != 0 || doneCnt != 1 || toCnt != 0 || ovCnt != 0) begin
            errors++;
            $display("[TB] FAIL rstmid_status: got extra=%0d done=%0d to=%0d ov=%0d expected 0 1 0 0",
                     obsW.size(), doneCnt, toCnt, ovCnt);
        end
    endtask

    initial begin
        $display("[TB] sb_packet_framer bench start");
        test_reset();
        test_no_data();
        test_data_same();
        test_random();
        test_data_late();
        test_timeout();
        test_backpressure();
        test_overrun();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: got no completion expected finish before time limit");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
